// File: rtl/sram_spi_byte_ctrl.sv
// Single-byte READ/WRITE command controller for a 23A1024 serial SRAM.
// Takes one valid/ready request, shifts out a 40-bit SPI mode-0 frame
// (instruction, 24-bit address, data byte) and returns the read byte on a
// one-cycle response strobe. SCK half-period is CLK_DIV system clocks.
module sram_spi_byte_ctrl #(
   parameter int CLK_DIV = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [16:0] req_addr,
   input  logic [7:0]  req_wdata,
   output logic        rsp_valid,
   output logic [7:0]  rsp_rdata,
   output logic        busy,
   output logic        sck,
   output logic        cs,
   output logic        mosi,
   input  logic        miso,
   output logic        HOLD_ENABLE
);

   localparam int              CW          = $clog2(2 * CLK_DIV) + 1;
   localparam logic [CW-1:0]   L_ONE       = CW'(1);
   localparam logic [CW-1:0]   L_HALF_END  = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0]   L_DESEL_END = CW'(2 * CLK_DIV - 1);
   localparam logic [5:0]      L_LAST_BIT  = 6'd39;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CS_SETUP,
      S_SHIFT,
      S_CS_HOLD,
      S_DESELECT
   } state_t;

   state_t         r_state;
   logic [CW-1:0]  r_cnt;
   logic [5:0]     r_bit;
   logic           r_we;
   logic           r_ready;
   logic           r_busy;
   logic           r_sck;
   logic           r_cs;
   logic           r_mosi;
   logic           r_rsp_valid;
   logic [7:0]     r_rdata;
   // Bits 38..0 of the frame; bit 39 goes straight to mosi on accept.
   logic [38:0]    r_frame;
   logic [7:0]     r_rx;

   logic           w_accept;
   logic           w_half_done;
   logic           w_sck_rise;
   logic           w_sck_fall;
   logic [39:0]    w_frame;

   assign w_accept    = (r_state == S_IDLE) && r_ready && req_valid;
   assign w_half_done = (r_cnt == L_HALF_END);
   // miso is sampled on every edge that takes sck low->high, including the
   // first one leaving CS_SETUP.
   assign w_sck_rise  = w_half_done &&
                        ((r_state == S_CS_SETUP) ||
                         ((r_state == S_SHIFT) && !r_sck && (r_bit != L_LAST_BIT)));
   assign w_sck_fall  = w_half_done && (r_state == S_SHIFT) && r_sck;
   assign w_frame     = {(req_we ? 8'h02 : 8'h03), 7'b0, req_addr,
                         (req_we ? req_wdata : 8'h00)};

   assign req_ready   = r_ready;
   assign busy        = r_busy;
   assign sck         = r_sck;
   assign cs          = r_cs;
   assign mosi        = r_mosi;
   assign rsp_valid   = r_rsp_valid;
   assign rsp_rdata   = r_rdata;
   assign HOLD_ENABLE = 1'b1;

   // Transaction sequencer: state, timing counters and all registered pin outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_bit       <= '0;
         r_we        <= 1'b0;
         r_ready     <= 1'b0;
         r_busy      <= 1'b0;
         r_sck       <= 1'b0;
         r_cs        <= 1'b1;
         r_mosi      <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rdata     <= 8'h00;
      end else begin
         r_rsp_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_ready <= 1'b1;
               if (w_accept) begin
                  r_we    <= req_we;
                  r_state <= S_CS_SETUP;
                  r_cs    <= 1'b0;
                  r_sck   <= 1'b0;
                  r_mosi  <= w_frame[39];
                  r_cnt   <= '0;
                  r_ready <= 1'b0;
                  r_busy  <= 1'b1;
               end
            end
            S_CS_SETUP: begin
               if (w_half_done) begin
                  r_state <= S_SHIFT;
                  r_sck   <= 1'b1;
                  r_cnt   <= '0;
                  r_bit   <= '0;
               end else begin
                  r_cnt <= r_cnt + L_ONE;
               end
            end
            S_SHIFT: begin
               if (w_half_done) begin
                  r_cnt <= '0;
                  if (r_sck) begin
                     // High phase over: drop sck and present the next bit.
                     r_sck  <= 1'b0;
                     r_mosi <= r_frame[38];
                  end else if (r_bit == L_LAST_BIT) begin
                     r_state <= S_CS_HOLD;
                  end else begin
                     r_sck <= 1'b1;
                     r_bit <= r_bit + 6'd1;
                  end
               end else begin
                  r_cnt <= r_cnt + L_ONE;
               end
            end
            S_CS_HOLD: begin
               if (w_half_done) begin
                  r_state     <= S_DESELECT;
                  r_cs        <= 1'b1;
                  r_mosi      <= 1'b0;
                  r_rsp_valid <= 1'b1;
                  r_cnt       <= '0;
                  if (!r_we) begin
                     r_rdata <= r_rx;
                  end
               end else begin
                  r_cnt <= r_cnt + L_ONE;
               end
            end
            S_DESELECT: begin
               if (r_cnt == L_DESEL_END) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
                  r_ready <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + L_ONE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // Frame and receive shift registers; pure datapath, so no reset.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_frame <= w_frame[38:0];
      end else if (w_sck_fall) begin
         r_frame <= {r_frame[37:0], 1'b0};
      end
      if (w_sck_rise) begin
         r_rx <= {r_rx[6:0], miso};
      end
   end

endmodule

// File: tb/tb_sram_spi_byte_ctrl.sv
// Self-checking bench for sram_spi_byte_ctrl: a CLK_DIV=2 and a CLK_DIV=1
// instance, each wired to a behavioural 23A1024 byte-mode memory model.
module tb_sram_spi_byte_ctrl;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   int          cyc   = 0;

   logic [1:0]  s_valid = '0;
   logic [1:0]  s_we    = '0;
   logic [16:0] s_addr  [2] = '{17'h0, 17'h0};
   logic [7:0]  s_wdata [2] = '{8'h0, 8'h0};
   logic [1:0]  s_ready, s_rsp, s_busy, s_sck, s_cs, s_mosi, s_miso, s_hold;
   logic [7:0]  s_rdata [2];

   int n_chk  = 0;
   int n_pass = 0;

   typedef struct {
      int          inst;
      logic        we;
      logic [16:0] addr;
      logic [7:0]  wd;
      logic [39:0] frame;
      logic [7:0]  rd;
   } vec_t;

   vec_t tbl [7];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   sram_spi_byte_ctrl #(.CLK_DIV(2)) u_dut2 (
      .clk(clk), .rst(rst_n),
      .req_valid(s_valid[0]), .req_ready(s_ready[0]), .req_we(s_we[0]),
      .req_addr(s_addr[0]), .req_wdata(s_wdata[0]),
      .rsp_valid(s_rsp[0]), .rsp_rdata(s_rdata[0]), .busy(s_busy[0]),
      .sck(s_sck[0]), .cs(s_cs[0]), .mosi(s_mosi[0]), .miso(s_miso[0]),
      .HOLD_ENABLE(s_hold[0])
   );

   sram_spi_byte_ctrl #(.CLK_DIV(1)) u_dut1 (
      .clk(clk), .rst(rst_n),
      .req_valid(s_valid[1]), .req_ready(s_ready[1]), .req_we(s_we[1]),
      .req_addr(s_addr[1]), .req_wdata(s_wdata[1]),
      .rsp_valid(s_rsp[1]), .rsp_rdata(s_rdata[1]), .busy(s_busy[1]),
      .sck(s_sck[1]), .cs(s_cs[1]), .mosi(s_mosi[1]), .miso(s_miso[1]),
      .HOLD_ENABLE(s_hold[1])
   );

   // Memory model: captures mosi on sck rise, drives miso on sck fall.
   for (genvar k = 0; k < 2; k++) begin : g_mem
      logic [7:0]  mem [131072];
      int          cnt       = 0;
      logic [39:0] sh        = '0;
      logic [39:0] frame     = '0;
      logic [7:0]  rd        = '0;
      logic        so        = 1'b0;
      int          viol_sck  = 0;
      int          viol_mosi = 0;
      int          rsp_cnt   = 0;

      assign s_miso[k] = so;

      initial begin
         for (int a = 0; a < 131072; a++) mem[a] = 8'h00;
      end

      always @(posedge s_sck[k] or negedge s_sck[k] or posedge s_cs[k]) begin
         if (s_cs[k]) begin
            if (cnt == 40) frame = sh;
            cnt = 0;
            so  = 1'b0;
         end else if (s_sck[k]) begin
            sh  = {sh[38:0], s_mosi[k]};
            cnt = cnt + 1;
            if (cnt == 32 && sh[31:24] == 8'h03) rd = mem[sh[16:0]];
            if (cnt == 40 && sh[39:32] == 8'h02) mem[sh[24:8]] = sh[7:0];
         end else if (cnt >= 32 && cnt < 40) begin
            so = rd[39 - cnt];
         end
      end

      always @(posedge s_sck[k] or negedge s_sck[k]) begin
         if (rst_n && s_cs[k]) viol_sck++;
      end

      always @(negedge clk) begin
         if (s_cs[k] && s_mosi[k]) viol_mosi++;
         if (s_rsp[k]) rsp_cnt++;
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // Wait (bounded) at negedges until instance k is ready, then let the accept edge pass.
   task automatic accept(input int k, input string name, output int t_acc);
      int w = 0;
      while (!s_ready[k] && w < 100) begin @(negedge clk); w++; end
      check({name, " ready seen"}, 64'(s_ready[k]), 64'(1));
      @(posedge clk);
      @(negedge clk);
      t_acc = cyc;
   endtask

   task automatic wait_rsp(input int k, output int t_rsp, output int low);
      int w = 0;
      low = 0;
      while (!s_rsp[k] && w < 400) begin
         if (!s_cs[k]) low++;
         @(negedge clk);
         w++;
      end
      t_rsp = cyc;
   endtask

   task automatic run_txn(input vec_t v, input string name);
      int k  = v.inst;
      int cd = (v.inst == 0) ? 2 : 1;
      int t_acc, t_rsp, low;
      logic [39:0] fr;
      @(negedge clk);
      s_valid[k] = 1'b1; s_we[k] = v.we; s_addr[k] = v.addr; s_wdata[k] = v.wd;
      accept(k, name, t_acc);
      // Scramble inputs: the controller must use the latched request.
      s_valid[k] = 1'b0; s_we[k] = ~v.we; s_addr[k] = ~v.addr; s_wdata[k] = ~v.wd;
      check({name, " busy"},  64'(s_busy[k]),  64'(1));
      check({name, " ready"}, 64'(s_ready[k]), 64'(0));
      check({name, " cs low"}, 64'(s_cs[k]),   64'(0));
      wait_rsp(k, t_rsp, low);
      check({name, " rsp seen"}, 64'(s_rsp[k]), 64'(1));
      check({name, " rsp cycle offset"}, 64'(t_rsp + 1 - t_acc), 64'(82 * cd + 1));
      check({name, " cs low cycles"}, 64'(low), 64'(82 * cd));
      check({name, " cs high at rsp"}, 64'(s_cs[k]), 64'(1));
      check({name, " rdata"}, 64'(s_rdata[k]), 64'(v.rd));
      fr = (k == 0) ? g_mem[0].frame : g_mem[1].frame;
      check({name, " mosi frame"}, 64'(fr), 64'(v.frame));
      @(negedge clk);
      check({name, " rsp one cycle"}, 64'(s_rsp[k]), 64'(0));
      check({name, " rdata held"}, 64'(s_rdata[k]), 64'(v.rd));
   endtask

   // Held req_valid: write 0x00000=0x11 then read 0x00000 back to back.
   task automatic back_to_back();
      int r0, t1, t2, n1, n2, low, w;
      r0 = g_mem[0].rsp_cnt;
      @(negedge clk);
      s_valid[0] = 1'b1; s_we[0] = 1'b1; s_addr[0] = 17'h00000; s_wdata[0] = 8'h11;
      accept(0, "b2b first", t1);
      s_we[0] = 1'b0; s_wdata[0] = 8'h00;
      wait_rsp(0, n1, low);
      check("b2b first rsp", 64'(s_rsp[0]), 64'(1));
      w = 0;
      while (!s_ready[0] && w < 50) begin @(negedge clk); w++; end
      check("b2b ready again", 64'(s_ready[0]), 64'(1));
      @(posedge clk);
      @(negedge clk);
      t2 = cyc;
      s_valid[0] = 1'b0;
      check("b2b accept after cs rise", 64'(t2 - (n1 + 1)), 64'(4));
      check("b2b second frame cs", 64'(s_cs[0]), 64'(0));
      wait_rsp(0, n2, low);
      check("b2b second rsp", 64'(s_rsp[0]), 64'(1));
      check("b2b read data", 64'(s_rdata[0]), 64'(8'h11));
      repeat (10) @(negedge clk);
      check("b2b rsp pulses", 64'(g_mem[0].rsp_cnt - r0), 64'(2));
   endtask

   // Reset during SHIFT bit 20 of a write 0x00010=0x5A.
   task automatic reset_abort();
      int t_acc, w, r0;
      vec_t rv;
      @(negedge clk);
      s_valid[0] = 1'b1; s_we[0] = 1'b1; s_addr[0] = 17'h00010; s_wdata[0] = 8'h5A;
      accept(0, "abort write", t_acc);
      s_valid[0] = 1'b0;
      r0 = g_mem[0].rsp_cnt;
      w = 0;
      while (g_mem[0].cnt < 21 && w < 200) begin @(negedge clk); w++; end
      check("abort reached bit 20", 64'(g_mem[0].cnt), 64'(21));
      rst_n = 1'b0;
      #1;
      check("abort cs", 64'(s_cs[0]), 64'(1));
      check("abort sck", 64'(s_sck[0]), 64'(0));
      check("abort mosi", 64'(s_mosi[0]), 64'(0));
      check("abort busy", 64'(s_busy[0]), 64'(0));
      check("abort ready", 64'(s_ready[0]), 64'(0));
      check("abort rdata cleared", 64'(s_rdata[0]), 64'(8'h00));
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("abort ready after release", 64'(s_ready[0]), 64'(1));
      check("abort no rsp", 64'(g_mem[0].rsp_cnt - r0), 64'(0));
      rv = '{0, 1'b0, 17'h00010, 8'h00, 40'h0300001000, 8'h00};
      run_txn(rv, "read after abort");
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached, %0d/%0d done", n_pass, n_chk);
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0] = '{0, 1'b1, 17'h1A5A5, 8'hC3, 40'h0201A5A5C3, 8'h00};
      tbl[1] = '{0, 1'b0, 17'h1A5A5, 8'h00, 40'h0301A5A500, 8'hC3};
      tbl[2] = '{0, 1'b1, 17'h1FFFF, 8'hFF, 40'h0201FFFFFF, 8'h11};
      tbl[3] = '{0, 1'b0, 17'h00000, 8'h00, 40'h0300000000, 8'h11};
      tbl[4] = '{0, 1'b0, 17'h1FFFF, 8'h00, 40'h0301FFFF00, 8'hFF};
      tbl[5] = '{1, 1'b1, 17'h00123, 8'hA5, 40'h02000123A5, 8'h00};
      tbl[6] = '{1, 1'b0, 17'h00123, 8'h00, 40'h0300012300, 8'hA5};

      #12;
      for (int k = 0; k < 2; k++) begin
         check("reset cs",        64'(s_cs[k]),    64'(1));
         check("reset sck",       64'(s_sck[k]),   64'(0));
         check("reset mosi",      64'(s_mosi[k]),  64'(0));
         check("reset ready",     64'(s_ready[k]), 64'(0));
         check("reset rsp_valid", 64'(s_rsp[k]),   64'(0));
         check("reset rdata",     64'(s_rdata[k]), 64'(8'h00));
         check("reset busy",      64'(s_busy[k]),  64'(0));
         check("reset hold",      64'(s_hold[k]),  64'(1));
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("ready after release div2", 64'(s_ready[0]), 64'(1));
      check("ready after release div1", 64'(s_ready[1]), 64'(1));

      for (int i = 0; i < 7; i++) begin
         if (i == 2) back_to_back();
         run_txn(tbl[i], $sformatf("vec%0d", i));
      end

      reset_abort();

      check("sck toggled with cs high", 64'(g_mem[0].viol_sck + g_mem[1].viol_sck), 64'(0));
      check("mosi high with cs high", 64'(g_mem[0].viol_mosi + g_mem[1].viol_mosi), 64'(0));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
